reuleaux_sched: RTL

Top-level sequencer for the Reuleaux-triangle drawer. Latches centre and diameter, computes the three arc centres, then runs the three `circle_fsm`-based segment engines (blue c1, green c2, red c3) one at a time. It owns the single VGA pixel-write port: only the active engine's pixels are forwarded, through a registered mux. It presents one start/done handshake to the task top level.

---
 rtl/reuleaux_sched.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/reuleaux_sched.sv
// reuleaux_sched
//   Top-level sequencer for the Reuleaux-triangle drawer. Latches centre and
//   diameter on start, computes the three arc centres, then runs the three
//   segment engines (c1, c2, c3) one after another. Only the active engine's
//   pixels reach the VGA port, through a one-cycle registered mux.
//
//   Optional feature macro: REULEAUX_CLIP_EN
//     defined   - forwarded pixels outside [0,SCREEN_W) x [0,SCREEN_H) are
//                 dropped (no strobe, vga_x/vga_y hold).
//     undefined - every forwarded pixel strobes; coordinates are truncated.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   start / done        level handshake with the task top level
//   centre_x/_y, diameter   triangle parameters (latched on IDLE->CALC)
//   seg_start[2:0]      per-engine start, one-hot while running
//   seg_cx/seg_cy/seg_r centre and radius for the active engine
//   seg_done[2:0]       per-engine done
//   seg_x/seg_y         engine pixel coordinates, engine n at [n*10 +: 10]
//                       and [n*9 +: 9] (signed)
//   seg_plot[2:0]       per-engine pixel valid
//   vga_x/vga_y/vga_plot  pixel write port to the VGA adapter
//
// state | meaning
// IDLE  | waiting for start, inputs latched on exit
// CALC  | registering the three arc centres
// RUNn  | engine n running, seg_start[n-1] high, its pixels forwarded
// RELn  | start released, waiting for engine n's done to drop
// DONE  | drawing complete, waiting for start to drop

module reuleaux_sched #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        centre_x,
  input  logic [6:0]        centre_y,
  input  logic [7:0]        diameter,
  output logic              done,
  output logic [2:0]        seg_start,
  output logic signed [9:0] seg_cx,
  output logic signed [8:0] seg_cy,
  output logic [7:0]        seg_r,
  input  logic [2:0]        seg_done,
  input  logic [29:0]       seg_x,
  input  logic [26:0]       seg_y,
  input  logic [2:0]        seg_plot,
  output logic [7:0]        vga_x,
  output logic [6:0]        vga_y,
  output logic              vga_plot
);

  typedef enum logic [3:0] {
    S_IDLE, S_CALC, S_RUN1, S_REL1, S_RUN2, S_REL2, S_RUN3, S_REL3, S_DONE
  } state_t;

  localparam logic [9:0] X_LIM = 10'(SCREEN_W);
  localparam logic [8:0] Y_LIM = 9'(SCREEN_H);

  state_t state, state_nxt;

  logic [7:0] lat_x;
  logic [6:0] lat_y;
  logic [7:0] lat_d;

  logic signed [9:0] c1x, c2x, c3x;
  logic signed [8:0] c1y, c3y;

  // ---------------- centre arithmetic ----------------
  // 296/1024 ~= sqrt(3)/6; 255*296 fits comfortably in 18 bits.
  logic [17:0] prod;
  logic [9:0]  r6, r3, half_d, cx10, cy10;
  logic [9:0]  c1x_n, c2x_n, cy_lo_n, c3y_n;

  always_comb begin
    prod    = 18'(lat_d) * 18'd296;
    r6      = {2'b00, prod[17:10]};
    r3      = {r6[8:0], 1'b0};
    half_d  = {3'b000, lat_d[7:1]};
    cx10    = {2'b00, lat_x};
    cy10    = {3'b000, lat_y};
    c1x_n   = cx10 + half_d;
    c2x_n   = cx10 - half_d;
    cy_lo_n = cy10 + r6;
    c3y_n   = cy10 - r3;
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  logic [1:0] sel;   // engine whose centre / pixels are selected
  logic       run;   // pixel forwarding enabled

  always_comb begin
    state_nxt = state;
    seg_start = 3'b000;
    done      = 1'b0;
    sel       = 2'd0;
    run       = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_CALC;
      S_CALC: state_nxt = S_RUN1;
      S_RUN1: begin
        seg_start = 3'b001;
        run       = 1'b1;
        if (seg_done[0]) state_nxt = S_REL1;
      end
      S_REL1: if (!seg_done[0]) state_nxt = S_RUN2;
      S_RUN2: begin
        seg_start = 3'b010;
        run       = 1'b1;
        sel       = 2'd1;
        if (seg_done[1]) state_nxt = S_REL2;
      end
      S_REL2: begin
        sel = 2'd1;
        if (!seg_done[1]) state_nxt = S_RUN3;
      end
      S_RUN3: begin
        seg_start = 3'b100;
        run       = 1'b1;
        sel       = 2'd2;
        if (seg_done[2]) state_nxt = S_REL3;
      end
      S_REL3: begin
        sel = 2'd2;
        if (!seg_done[2]) state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (!start) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- engine-facing muxes ----------------
  logic [9:0] fwd_x;
  logic [8:0] fwd_y;
  logic       fwd_plot;

  always_comb begin
    seg_cx   = c1x;
    seg_cy   = c1y;
    fwd_x    = seg_x[9:0];
    fwd_y    = seg_y[8:0];
    fwd_plot = 1'b0;
    case (sel)
      2'd1: begin
        seg_cx   = c2x;
        seg_cy   = c1y;            // c1 and c2 share the same y
        fwd_x    = seg_x[19:10];
        fwd_y    = seg_y[17:9];
        fwd_plot = seg_plot[1];
      end
      2'd2: begin
        seg_cx   = c3x;
        seg_cy   = c3y;
        fwd_x    = seg_x[29:20];
        fwd_y    = seg_y[26:18];
        fwd_plot = seg_plot[2];
      end
      default: fwd_plot = seg_plot[0];
    endcase
    fwd_plot = fwd_plot & run;
  end

  assign seg_r = lat_d;

  logic accept;
`ifdef REULEAUX_CLIP_EN
  logic in_range;
  always_comb begin
    in_range = !fwd_x[9] && (fwd_x < X_LIM) && !fwd_y[8] && (fwd_y < Y_LIM);
    accept   = fwd_plot & in_range;
  end
  logic unused_bits;
  assign unused_bits = ^{prod[9:0], cy_lo_n[9], c3y_n[9], X_LIM, Y_LIM};
`else
  assign accept = fwd_plot;
  logic unused_bits;
  assign unused_bits = ^{prod[9:0], cy_lo_n[9], c3y_n[9], fwd_x[9:8],
                         fwd_y[8:7], X_LIM, Y_LIM};
`endif

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_x    <= '0;
      lat_y    <= '0;
      lat_d    <= '0;
      c1x      <= '0;
      c2x      <= '0;
      c3x      <= '0;
      c1y      <= '0;
      c3y      <= '0;
      vga_x    <= '0;
      vga_y    <= '0;
      vga_plot <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        lat_x <= centre_x;
        lat_y <= centre_y;
        lat_d <= diameter;
      end
      if (state == S_CALC) begin
        c1x <= c1x_n;
        c2x <= c2x_n;
        c3x <= cx10;
        c1y <= cy_lo_n[8:0];
        c3y <= c3y_n[8:0];
      end
      if (accept) begin
        vga_x <= fwd_x[7:0];
        vga_y <= fwd_y[6:0];
      end
      vga_plot <= accept;
    end
  end

endmodule
